// File: rtl/des_pkg.sv
// des_pkg: DES S-box tables (standard row-major, row={g6,g1}, col=g[5:2]), lookup helper and LANES legality check.
package des_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] SBOX [1:8][0:63] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};
  function automatic logic [3:0] sbox(input logic [2:0] box_idx, input logic [6:1] g6);
    return SBOX[int'(box_idx) + 1][{g6[6], g6[1], g6[5:2]}];
  endfunction
  function automatic bit lanes_ok(input int n);
    return n == 1 || n == 2 || n == 4 || n == 8;
  endfunction
endpackage

// File: rtl/des_sbox_lane.sv
// des_sbox_lane: one combinational S-box lookup.
//   i_box [2:0] box index (0 = S1 .. 7 = S8), i_g [6:1] 6-bit group, o_s [4:1] S-box output.
module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0] i_box,
  input  logic [6:1] i_g,
  output logic [4:1] o_s
);
  assign o_s = sbox(i_box, i_g);
endmodule

// File: rtl/des_sbox_seq.sv
// des_sbox_seq: sequential DES S-layer, LANES S-boxes per cycle over 8/LANES cycles, valid/ready on both sides.
//   clk, rst_n (sync active-low); in_valid/in_ready/in_data[48:1]/in_key[48:1] operand side;
//   out_valid/out_ready/out_data[32:1] result side.
module des_sbox_seq
  import des_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:1] in_data,
  input  logic [48:1] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:1] out_data
);
  localparam int STEPS = 8 / LANES;
  localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;
  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
  end
  state_t          r_state, w_next;
  logic [SW-1:0]   r_step;
  logic [48:1]     r_op;
  logic [32:1]     r_res;
  logic            w_last, w_rdy, w_acc;
  logic [2:0]      w_box [LANES];
  logic [6:1]      w_grp [LANES];
  logic [4:1]      w_nib [LANES];
  assign w_last = r_step == SW'(STEPS - 1);
  assign w_rdy  = r_state == IDLE || (r_state == DONE && out_ready);
  assign w_acc  = in_valid && w_rdy;
  // Outputs are forced low while reset is held, not just after the reset edge.
  assign in_ready  = rst_n && w_rdy;
  assign out_valid = rst_n && r_state == DONE;
  assign out_data  = rst_n ? r_res : '0;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_box[k] = 3'(int'(r_step) * LANES + k);
    // Box b lives in operand bits [48-6b:43-6b], i.e. 42-6b above bit 1.
    assign w_grp[k] = 6'(r_op >> (42 - 6 * int'(w_box[k])));
    des_sbox_lane u_lane (
      .i_box (w_box[k]),
      .i_g   (w_grp[k]),
      .o_s   (w_nib[k])
    );
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (in_valid ? BUSY : IDLE) :
             r_state == BUSY ? (w_last ? DONE : BUSY) :
             out_ready       ? (in_valid ? BUSY : IDLE) : DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_op    <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      r_step  <= (r_state == BUSY && !w_last) ? r_step + SW'(1) : '0;
      if (w_acc) r_op <= in_data ^ in_key;
      if (r_state == BUSY)
        for (int k = 0; k < LANES; k++) r_res[32 - 4 * int'(w_box[k]) -: 4] <= w_nib[k];
    end
  end
endmodule
